lfsr_burst_ctrl: RTL and testbench
==================================

Name: lfsr_burst_ctrl

Overview:
Sequencer for the 8-bit Fibonacci PRBS generator. The feedback taps are q[7]^q[5]^q[4]^q[2] and the register shifts left into q[0].
- On a start request it loads a seed. It then advances the LFSR once per prescaler tick and emits a programmed burst of words over a valid/ready stream.
- When the burst is complete it pulses done.
- It replaces the free-running divider and ini-style preset with a controlled, back-pressurable burst engine.

Parameters:
PRESCALE_W, 25, width of the prescaler counter and of div_cfg.
LEN_W, 8, width of the burst-length input and of the internal word counter.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset. Asserting it (low) immediately forces the reset state.
start  in  1  burst request; sampled only in IDLE.
seed  in  8  LFSR seed; captured in LOAD.
len  in  LEN_W  number of words in the burst; captured in LOAD.
div_cfg  in  PRESCALE_W  tick period minus 1; captured in LOAD.
abort  in  1  cancels the burst from any non-IDLE state.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on normal burst completion.
out_data  out  8  current LFSR word.
out_valid  out  1  word available.
out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset values: state=IDLE, lfsr=8'hFF, prescaler=0, word count=0, busy=0, done=0, out_valid=0, out_data=8'hFF.
- out_data always reflects the LFSR register; it is registered and has no combinational path from inputs.
- Step function: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[2]}. The period from any non-zero state is 255.
- IDLE: if start=1 at an edge, go to LOAD. The start input is otherwise ignored, including while busy.
- LOAD (1 cycle):
  - lfsr <= seed, except that seed=0 loads 8'hFF (zero-lock guard).
  - Capture len and div_cfg; prescaler <= 0; count <= 0.
  - If len=0, go to DONE; otherwise go to WAIT.
- WAIT:
  - If prescaler == div_cfg_q: step the LFSR, prescaler <= 0, out_valid <= 1, go to OUT.
  - Otherwise prescaler increments.
  - With div_cfg=0 there is one step per clock, so the first out_valid rises 2 edges after the edge that sampled start.
- OUT: hold out_valid and out_data stable until out_valid & out_ready at an edge. On that handshake:
  - out_valid <= 0 and count increments.
  - If count == len_q-1, go to DONE; otherwise go to WAIT.
  - The LFSR and prescaler are frozen while stalled; there is no word loss or skip under backpressure.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy is still high in DONE.
- abort=1 in LOAD/WAIT/OUT/DONE: go to IDLE at the next edge.
  - out_valid and done are forced to 0.
  - No done pulse is produced.
  - The LFSR keeps its current value.
- abort takes priority over the handshake and the tick in the same cycle.
- Asynchronous reset mid-burst: all outputs immediately take their reset values. out_valid drops with no handshake.
- The word counter is LEN_W wide. A len of 2^LEN_W-1 is the maximum burst, and there is no wrap inside a burst.
- Prescaler compare uses equality on PRESCALE_W bits, so the maximum div_cfg gives 2^PRESCALE_W clocks per step.

Decomposition:
- Shared package lfsr_pkg:
  - TAP_MASK=8'hB4 (bits 7,5,4,2).
  - DEFAULT_SEED=8'hFF.
  - State encoding IDLE/LOAD/WAIT/OUT/DONE as 3-bit localparams.
- Sub-module lfsr_core: 8-bit register with async active-low reset to DEFAULT_SEED, synchronous load (seed input) and step enable. Load has priority over step.
- The FSM, prescaler and counter stay in lfsr_burst_ctrl.

Test Plan:
- Basic burst: seed=8'hFF, len=5, div_cfg=0, out_ready=1.
  - Required words: FE, FC, F8, F1, E3.
  - One word every 2 clocks (WAIT→OUT→WAIT cycle).
  - Single done pulse, then busy=0.
- Prescale: div_cfg=3, len=2, seed=8'h01.
  - Exactly 4 WAIT clocks precede each out_valid rise.
  - Words 02, 04.
- Backpressure: len=3, out_ready held 0 for 10 cycles after the first valid.
  - out_data stays FE and out_valid stays high.
  - After release the remaining words are FC, F8 with no skip.
- Zero seed and len=0:
  - seed=0, len=3 gives words FE, FC, F8.
  - seed=8'h5A, len=0 gives done 2 edges after start, with no out_valid.
- Abort and reset:
  - abort during OUT: out_valid drops next edge, no done pulse, busy=0.
  - rst low mid-WAIT: outputs reset asynchronously, out_data=8'hFF.
  - A following start works normally.
- Period: seed=8'h01, len=255, div_cfg=0.
  - The 255th word equals 8'h01.
  - All 255 words are distinct and non-zero.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the burst-controlled 8-bit Fibonacci PRBS generator:
// tap mask, default seed, FSM encoding and the LFSR step / seed guard helpers.
package lfsr_pkg;

    localparam logic [7:0] TAP_MASK     = 8'hB4;   // taps on bits 7,5,4,2
    localparam logic [7:0] DEFAULT_SEED = 8'hFF;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_WAIT = S_WAIT,
        ST_OUT  = S_OUT,
        ST_DONE = S_DONE
    } state_t;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & TAP_MASK)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    function automatic logic [7:0] seed_guard(input logic [7:0] s);
        return (s == 8'h00) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit Fibonacci LFSR register with synchronous load and step enable.
// Load wins over step; asynchronous reset returns the register to the default seed.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // LFSR state register: reset, load or advance by one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer around the 8-bit PRBS generator: loads a seed on request,
// advances the LFSR once per prescaler tick and streams a programmed number
// of words over valid/ready, then pulses done. abort returns to IDLE at once.
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int PRESCALE_W = 25,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            seed,
    input  logic [LEN_W-1:0]      len,
    input  logic [PRESCALE_W-1:0] div_cfg,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]      LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]      LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [PRESCALE_W-1:0]   presc_r;
    logic [PRESCALE_W-1:0]   div_q_r;
    logic [LEN_W-1:0]        count_r;
    logic [LEN_W-1:0]        len_q_r;

    logic                    load_s;
    logic                    step_s;
    logic                    tick_s;
    logic [7:0]              seed_s;
    logic [7:0]              lfsr_q_s;

    // LFSR control: load in LOAD, step on a prescaler tick in WAIT; abort suppresses both.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        tick_s = (presc_r == div_q_r);
        seed_s = seed_guard(seed);
        case (state_r)
            ST_LOAD: load_s = ~abort;
            ST_WAIT: step_s = ~abort & tick_s;
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
            end
        endcase
    end

    lfsr_core u_core (
        .clk   (clk),
        .rst_n (rst),
        .load  (load_s),
        .step  (step_s),
        .seed  (seed_s),
        .q     (lfsr_q_s)
    );

    // The data output is the LFSR register itself, so it carries no input path.
    assign out_data = lfsr_q_s;

    // Burst FSM with prescaler, word counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            div_q_r   <= PRESC_ZERO;
            count_r   <= LEN_ZERO;
            len_q_r   <= LEN_ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    len_q_r <= len;
                    div_q_r <= div_cfg;
                    presc_r <= PRESC_ZERO;
                    count_r <= LEN_ZERO;
                    if (len == LEN_ZERO) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tick_s) begin
                        presc_r   <= PRESC_ZERO;
                        out_valid <= 1'b1;
                        state_r   <= ST_OUT;
                    end else begin
                        presc_r   <= presc_r + PRESC_ONE;
                    end
                end
                ST_OUT: begin
                    // LFSR and prescaler stay frozen until the consumer takes the word.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count_r   <= count_r + LEN_ONE;
                        if (count_r == (len_q_r - LEN_ONE)) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed testbench for lfsr_burst_ctrl: a table of bursts with hand-computed
// words and timing, plus sequences for backpressure, abort, reset and period.
module tb_lfsr_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic [7:0]  len;
    logic [24:0] div_cfg;
    logic        abort;
    logic        busy;
    logic        done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_bad;

    logic [7:0] got[$];
    int         done_cnt;
    int         done_cyc;
    int         first_valid_cyc;
    int         timed_out;

    typedef struct {
        logic [7:0]      seed;
        logic [7:0]      len;
        logic [24:0]     div;
        int              nw;
        logic [4:0][7:0] w;   // w[0] is the first word
    } vec_t;

    vec_t vecs[6];

    lfsr_burst_ctrl #(.PRESCALE_W(25), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .len       (len),
        .div_cfg   (div_cfg),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference step: q[7]^q[5]^q[4]^q[2] shifted into bit 0.
    function automatic logic [7:0] ref_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[2]};
    endfunction

    // Issue a start and observe until busy falls; cycle c counts observations after the start edge.
    task automatic run_burst(input logic [7:0] s, input logic [7:0] l, input logic [24:0] d,
                             input int budget);
        got.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        timed_out = 1;
        seed = s; len = l; div_cfg = d; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!busy && c > 1) begin
                timed_out = 0;
                break;
            end
            tick();
        end
        check("burst_timeout", timed_out, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start = 1'b0; seed = 8'h00; len = 8'd0; div_cfg = 25'd0;
        abort = 1'b0; out_ready = 1'b1;

        vecs[0] = '{seed: 8'hFF, len: 8'd5, div: 25'd0, nw: 5,
                    w: {8'hE3, 8'hF1, 8'hF8, 8'hFC, 8'hFE}};
        vecs[1] = '{seed: 8'h01, len: 8'd2, div: 25'd3, nw: 2,
                    w: {8'h00, 8'h00, 8'h00, 8'h04, 8'h02}};
        vecs[2] = '{seed: 8'h00, len: 8'd3, div: 25'd0, nw: 3,
                    w: {8'h00, 8'h00, 8'hF8, 8'hFC, 8'hFE}};
        vecs[3] = '{seed: 8'h5A, len: 8'd0, div: 25'd0, nw: 0,
                    w: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{seed: 8'h5A, len: 8'd1, div: 25'd1, nw: 1,
                    w: {8'h00, 8'h00, 8'h00, 8'h00, 8'hB5}};
        vecs[5] = '{seed: 8'h80, len: 8'd2, div: 25'd2, nw: 2,
                    w: {8'h00, 8'h00, 8'h00, 8'h02, 8'h01}};

        #12;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Table-driven bursts with out_ready held high.
        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].seed, vecs[v].len, vecs[v].div, 700);
            check($sformatf("v%0d_nwords", v), got.size(), vecs[v].nw);
            for (int k = 0; k < vecs[v].nw && k < got.size(); k++)
                check($sformatf("v%0d_word%0d", v, k), got[k], vecs[v].w[k]);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_done_cyc", v), done_cyc,
                  int'(vecs[v].len) * (int'(vecs[v].div) + 2) + 2);
            check($sformatf("v%0d_first_valid", v), first_valid_cyc,
                  (vecs[v].len == 8'd0) ? -1 : int'(vecs[v].div) + 3);
            check($sformatf("v%0d_idle_done", v), done, 0);
            tick();
        end

        // Backpressure: hold ready low for 10 cycles once the first word is valid.
        out_ready = 1'b0;
        seed = 8'hFF; len = 8'd3; div_cfg = 25'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        check("bp_first_valid", out_valid, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold_data%0d", c), out_data, 8'hFE);
            check($sformatf("bp_hold_valid%0d", c), out_valid, 1);
        end
        out_ready = 1'b1;
        got.delete();
        done_cnt = 0;
        timed_out = 1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
            if (!busy) begin
                timed_out = 0;
                break;
            end
            tick();
        end
        check("bp_timeout", timed_out, 0);
        check("bp_nwords", got.size(), 3);
        if (got.size() == 3) begin
            check("bp_w0", got[0], 8'hFE);
            check("bp_w1", got[1], 8'hFC);
            check("bp_w2", got[2], 8'hF8);
        end
        check("bp_done_cnt", done_cnt, 1);
        tick();

        // Abort while a word is held in OUT.
        out_ready = 1'b0;
        seed = 8'hFF; len = 8'd5; div_cfg = 25'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        check("ab_valid_before", out_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid", out_valid, 0);
        check("ab_busy",  busy, 0);
        check("ab_done",  done, 0);
        check("ab_data_kept", out_data, 8'hFE);
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("ab_no_done_later", done_cnt, 0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a long WAIT.
        seed = 8'h01; len = 8'd2; div_cfg = 25'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("rw_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rw_busy",  busy, 0);
        check("rw_valid", out_valid, 0);
        check("rw_done",  done, 0);
        check("rw_data",  out_data, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // A normal burst after reset.
        run_burst(8'hFF, 8'd2, 8'd0, 50);
        check("post_rst_nwords", got.size(), 2);
        if (got.size() == 2) begin
            check("post_rst_w0", got[0], 8'hFE);
            check("post_rst_w1", got[1], 8'hFC);
        end
        check("post_rst_done", done_cnt, 1);
        tick();

        // Full period from seed 01: 255 distinct non-zero words ending back at 01.
        run_burst(8'h01, 8'd255, 25'd0, 600);
        check("per_nwords", got.size(), 255);
        if (got.size() == 255) begin
            logic [255:0] seen;
            logic [7:0]   m;
            int           dup;
            int           zero;
            int           model_err;
            seen = '0; dup = 0; zero = 0; model_err = 0;
            m = 8'h01;
            for (int k = 0; k < 255; k++) begin
                m = ref_step(m);
                if (got[k] != m) model_err++;
                if (got[k] == 8'h00) zero++;
                if (seen[got[k]]) dup++;
                seen[got[k]] = 1'b1;
            end
            check("per_last", got[254], 8'h01);
            check("per_model", model_err, 0);
            check("per_dup", dup, 0);
            check("per_zero", zero, 0);
        end
        check("per_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
